// File: rtl/accumulator_bank_pkg.sv
// accumulator_bank_pkg: shared state encoding, default widths and operand extension
package accumulator_bank_pkg;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_ACC_W  = 72;
   localparam int MAX_W      = 256;
   typedef enum logic [0:0] {ST_ACC = 1'b0, ST_DUMP = 1'b1} state_e;
   function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] d, input int w, input logic sgn);
      logic [MAX_W-1:0] r;
      for (int i = 0; i < MAX_W; i++) r[i] = (i < w) ? d[i] : (sgn & d[w-1]);
      return r;
   endfunction
endpackage

// File: rtl/acc_sat_add.sv
// acc_sat_add: accumulator adder with overflow detect; ACC_SATURATE_EN selects clamp, else wrap
module acc_sat_add
   import accumulator_bank_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] ext_data,
   input  logic             signed_mode,
   output logic [ACC_W-1:0] result,
   output logic             ovf
);
   logic [ACC_W:0] sum;
   always_comb begin
      sum = {1'b0, acc} + {1'b0, ext_data};
      // signed overflow: operands share a sign that the truncated sum does not
      ovf = signed_mode ? ((acc[ACC_W-1] == ext_data[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1])) : sum[ACC_W];
`ifdef ACC_SATURATE_EN
      result = !ovf ? sum[ACC_W-1:0] :
               !signed_mode ? {ACC_W{1'b1}} :
               acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
      result = sum[ACC_W-1:0];
`endif
   end
endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: NUM_CH wide accumulators with sticky overflow and a clear-on-read dump stream.
// Saturation is enabled by ACC_SATURATE_EN; otherwise sums wrap and only flag overflow.
module accumulator_bank
   import accumulator_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int NUM_CH = 4,
   localparam int CH_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              signed_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   input  logic              dump_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_ovf,
   output logic              busy
);
   state_e             state_q, state_d;
   logic [CH_W-1:0]    idx_q, idx_d;
   logic [ACC_W-1:0]   acc_q [NUM_CH];
   logic [ACC_W-1:0]   acc_d [NUM_CH];
   logic [NUM_CH-1:0]  ovf_q, ovf_d;
   logic               dump, in_ch_ok, in_fire, last, add_ovf;
   logic [ACC_W-1:0]   acc_sel, ext_d, add_res;

   assign dump      = (state_q == ST_DUMP);
   assign in_ready  = reset_n && !dump && !clear;
   assign in_ch_ok  = {1'b0, in_ch} < (CH_W+1)'(NUM_CH);
   assign in_fire   = in_valid && in_ready && in_ch_ok;
   assign last      = (idx_q == CH_W'(NUM_CH-1));
   assign acc_sel   = in_ch_ok ? acc_q[in_ch] : '0;
   assign ext_d     = ACC_W'(sign_ext(MAX_W'(in_data), DATA_W, signed_mode));
   assign out_valid = dump;
   assign busy      = dump;
   assign out_ch    = dump ? idx_q : '0;
   assign out_data  = dump ? acc_q[idx_q] : '0;
   assign out_ovf   = dump && ovf_q[idx_q];

   // one adder serves every channel since at most one is written per cycle
   acc_sat_add #(.ACC_W(ACC_W)) u_add (
      .acc         (acc_sel),
      .ext_data    (ext_d),
      .signed_mode (signed_mode),
      .result      (add_res),
      .ovf         (add_ovf)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = ST_ACC;
         idx_d   = '0;
         acc_d   = '{default: '0};
         ovf_d   = '0;
      end else if (!dump) begin
         if (in_fire) begin
            acc_d[in_ch] = add_res;
            ovf_d[in_ch] = ovf_q[in_ch] | add_ovf;
         end
         state_d = dump_req ? ST_DUMP : ST_ACC;
         idx_d   = '0;
      end else if (out_ready) begin
         acc_d[idx_q] = '0;
         ovf_d[idx_q] = 1'b0;
         idx_d        = last ? '0 : idx_q + 1'b1;
         state_d      = last ? ST_ACC : ST_DUMP;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_ACC;
         idx_q   <= '0;
         acc_q   <= '{default: '0};
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: randomized bench with a plain-arithmetic accumulator model.
module tb_accumulator_bank;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0, signed_mode = 1'b0, in_valid = 1'b0, dump_req = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, out_ovf, busy;
   logic [1:0]  in_ch = '0, out_ch;
   logic [63:0] in_data = '0;
   logic [71:0] out_data;

   int vectors = 0, errors = 0;
   logic [71:0] m_acc [4];
   logic        m_ovf [4];
   logic [71:0] exp_acc [4];
   logic        exp_ovf [4];
   logic [1:0]  cap_ch [4];
   logic [71:0] cap_data [4];
   logic        cap_ovf [4];
   int          nb;

   localparam logic signed [73:0] SMAX = 74'sh7FFFFFFFFFFFFFFFFF;
   localparam logic signed [73:0] SMIN = -SMAX - 74'sd1;
   localparam logic        [73:0] UMAX = 74'hFFFFFFFFFFFFFFFFFF;

   always #5 clk = ~clk;

   accumulator_bank dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .signed_mode(signed_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
      .dump_req(dump_req), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
   );

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) begin
         m_acc[i] = '0;
         m_ovf[i] = 1'b0;
      end
   endfunction

   // true-value arithmetic on wide integers, then clamp or wrap into 72 bits
   function automatic void model_add(int ch, logic [63:0] d, logic s);
      logic signed [73:0] a, e, t;
      logic [73:0] ut;
      if (s) begin
         a = $signed(m_acc[ch]);
         e = $signed(d);
         t = a + e;
         if (t > SMAX || t < SMIN) m_ovf[ch] = 1'b1;
`ifdef ACC_SATURATE_EN
         m_acc[ch] = (t > SMAX) ? SMAX[71:0] : (t < SMIN) ? SMIN[71:0] : t[71:0];
`else
         m_acc[ch] = t[71:0];
`endif
      end else begin
         ut = 74'(m_acc[ch]) + 74'(d);
         if (ut > UMAX) m_ovf[ch] = 1'b1;
`ifdef ACC_SATURATE_EN
         m_acc[ch] = (ut > UMAX) ? UMAX[71:0] : ut[71:0];
`else
         m_acc[ch] = ut[71:0];
`endif
      end
   endfunction

   task automatic send(input logic [1:0] ch, input logic [63:0] d, input logic s);
      in_valid = 1'b1; in_ch = ch; in_data = d; signed_mode = s;
      @(negedge clk);
      in_valid = 1'b0;
      model_add(int'(ch), d, s);
   endtask

   // pulses dump_req (optionally with a coincident input beat) and records every transferred beat
   task automatic do_dump(input bit rnd_ready, input bit with_beat, input logic [1:0] ch, input logic [63:0] d, input logic s);
      dump_req = 1'b1;
      if (with_beat) begin
         in_valid = 1'b1; in_ch = ch; in_data = d; signed_mode = s;
      end
      @(negedge clk);
      dump_req = 1'b0;
      in_valid = 1'b0;
      if (with_beat) model_add(int'(ch), d, s);
      for (int i = 0; i < 4; i++) begin
         exp_acc[i] = m_acc[i];
         exp_ovf[i] = m_ovf[i];
      end
      model_clear();
      nb = 0;
      for (int c = 0; c < 200 && nb < 4; c++) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            cap_ch[nb] = out_ch; cap_data[nb] = out_data; cap_ovf[nb] = out_ovf;
            nb++;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (out_data !== 72'd0 || out_ch !== 2'd0 || out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out got ch=%0d data=%h ovf=%b want 0", out_ch, out_data, out_ovf); end
      @(negedge clk);
      reset_n = 1'b1;
      model_clear();
      @(negedge clk);
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic_unsigned();
      send(2'd0, 64'd5, 1'b0);
      send(2'd1, 64'd7, 1'b0);
      do_dump(1'b0, 1'b0, '0, '0, 1'b0);
      vectors++; if (nb !== 4) begin errors++; $display("FAIL basic_beats got %0d want 4", nb); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
      for (int i = 0; i < nb; i++) begin
         vectors++; if (cap_ch[i] !== 2'(i) || cap_data[i] !== exp_acc[i] || cap_ovf[i] !== exp_ovf[i]) begin errors++; $display("FAIL basic_beat%0d got ch=%0d data=%h ovf=%b want ch=%0d data=%h ovf=%b", i, cap_ch[i], cap_data[i], cap_ovf[i], i, exp_acc[i], exp_ovf[i]); end
      end
      vectors++; if (cap_data[0] !== 72'd5 || cap_data[1] !== 72'd7 || cap_data[2] !== 72'd0) begin errors++; $display("FAIL basic_values got %0d %0d %0d want 5 7 0", cap_data[0], cap_data[1], cap_data[2]); end
      do_dump(1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < nb; i++) begin
         vectors++; if (cap_data[i] !== 72'd0 || cap_ovf[i] !== 1'b0) begin errors++; $display("FAIL redump_beat%0d got data=%h ovf=%b want 0", i, cap_data[i], cap_ovf[i]); end
      end
   endtask

   task automatic test_signed();
      send(2'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
      do_dump(1'b0, 1'b1, 2'd2, 64'd1, 1'b1);
      vectors++; if (nb !== 4) begin errors++; $display("FAIL signed_beats got %0d want 4", nb); end
      vectors++; if (cap_data[2] !== 72'hFF_FFFF_FFFF_FFFF_FFFE || cap_ovf[2] !== 1'b0) begin errors++; $display("FAIL signed_ch2 got data=%h ovf=%b want data=fffffffffffffffffe ovf=0", cap_data[2], cap_ovf[2]); end
      vectors++; if (cap_data[2] !== exp_acc[2]) begin errors++; $display("FAIL signed_model got %h want %h", cap_data[2], exp_acc[2]); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 300; i++) send(2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      do_dump(1'b1, 1'b0, '0, '0, 1'b0);
      vectors++; if (nb !== 4) begin errors++; $display("FAIL ovf_beats got %0d want 4", nb); end
      vectors++; if (cap_data[1] !== exp_acc[1] || cap_ovf[1] !== 1'b1) begin errors++; $display("FAIL ovf_ch1 got data=%h ovf=%b want data=%h ovf=1", cap_data[1], cap_ovf[1], exp_acc[1]); end
`ifdef ACC_SATURATE_EN
      vectors++; if (cap_data[1] !== 72'h7F_FFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL ovf_sat got %h want 7fffffffffffffffff", cap_data[1]); end
`endif
      vectors++; if (cap_ovf[0] !== 1'b0 || cap_ovf[2] !== 1'b0) begin errors++; $display("FAIL ovf_isolation got %b %b want 0 0", cap_ovf[0], cap_ovf[2]); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 25; k++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d[63:60] = 4'hF;
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            else send(2'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)));
         end
         do_dump(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         vectors++; if (nb !== 4) begin errors++; $display("FAIL rand%0d_beats got %0d want 4", r, nb); end
         for (int i = 0; i < nb; i++) begin
            vectors++; if (cap_ch[i] !== 2'(i) || cap_data[i] !== exp_acc[i] || cap_ovf[i] !== exp_ovf[i]) begin errors++; $display("FAIL rand%0d_beat%0d got ch=%0d data=%h ovf=%b want ch=%0d data=%h ovf=%b", r, i, cap_ch[i], cap_data[i], cap_ovf[i], i, exp_acc[i], exp_ovf[i]); end
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 4; i++) send(2'(i), 64'($urandom) + 64'd1, 1'b0);
      for (int i = 0; i < 4; i++) exp_acc[i] = m_acc[i];
      model_clear();
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         vectors++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== exp_acc[1]) begin errors++; $display("FAIL stall%0d got v=%b ch=%0d data=%h want v=1 ch=1 data=%h", c, out_valid, out_ch, out_data, exp_acc[1]); end
         vectors++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall%0d_flags got in_ready=%b busy=%b want 0 1", c, in_ready, busy); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         vectors++; if (out_valid !== 1'b1 || out_ch !== 2'(i) || out_data !== exp_acc[i]) begin errors++; $display("FAIL stall_resume%0d got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h", i, out_valid, out_ch, out_data, i, exp_acc[i]); end
         @(negedge clk);
      end
      out_ready = 1'b0;
      vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_end got v=%b busy=%b want 0 0", out_valid, busy); end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 4; i++) send(2'(i), 64'd100 + 64'(i), 1'b0);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++; if (out_ch !== 2'd2 || out_data !== m_acc[2]) begin errors++; $display("FAIL clear_pre got ch=%0d data=%h want ch=2 data=%h", out_ch, out_data, m_acc[2]); end
      clear = 1'b1; in_valid = 1'b1; in_ch = 2'd3; in_data = 64'd9; signed_mode = 1'b0;
      #1;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got %b want 0", in_ready); end
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      model_clear();
      vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_after got v=%b busy=%b want 0 0", out_valid, busy); end
      do_dump(1'b0, 1'b0, '0, '0, 1'b0);
      vectors++; if (nb !== 4) begin errors++; $display("FAIL clear_dump_beats got %0d want 4", nb); end
      for (int i = 0; i < nb; i++) begin
         vectors++; if (cap_data[i] !== 72'd0 || cap_ovf[i] !== 1'b0) begin errors++; $display("FAIL clear_ch%0d got data=%h ovf=%b want 0", i, cap_data[i], cap_ovf[i]); end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) send(2'(i), 64'hABCD + 64'(i), 1'b0);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 72'd0 || out_ch !== 2'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL areset_now got v=%b busy=%b ch=%0d data=%h in_ready=%b want all 0", out_valid, busy, out_ch, out_data, in_ready); end
      @(negedge clk);
      reset_n = 1'b1;
      model_clear();
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_state got busy=%b in_ready=%b want 0 1", busy, in_ready); end
      do_dump(1'b0, 1'b0, '0, '0, 1'b0);
      vectors++; if (nb !== 4) begin errors++; $display("FAIL areset_beats got %0d want 4", nb); end
      for (int i = 0; i < nb; i++) begin
         vectors++; if (cap_data[i] !== 72'd0) begin errors++; $display("FAIL areset_ch%0d got %h want 0", i, cap_data[i]); end
      end
   endtask

   initial begin
      model_clear();
      @(negedge clk);
      test_reset();
      test_basic_unsigned();
      test_signed();
      test_overflow();
      test_random();
      test_stall();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
